// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with OS-times oversampling driven by an external tick16 enable.
// Start bit is re-checked at mid-bit for glitch rejection; data and stop bits are sampled
// once per bit at counter = OS-1, i.e. roughly mid-bit relative to the start detection.
module uart_rx_os16 #(
  parameter int unsigned OS = 16
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       tick16,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(OS);
  localparam logic [CntW-1:0] CntLast = CntW'(OS - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OS / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            rxd_meta_q, rxd_s;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s      <= rxd_meta_q;
    end
  end

  // Receiver state, counters, shift register and registered output pulses.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic; everything holds except on tick cycles, pulses default low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (tick16) begin
      unique case (state_q)
        StIdle: begin
          if (!rxd_s) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_d = '0;
            if (!rxd_s) begin
              state_d = StData;
              bit_d   = 3'd0;
            end else begin
              // Start bit gone by mid-bit: treat as a glitch.
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            shreg_d = {rxd_s, shreg_q[7:1]};
            cnt_d   = '0;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_d = StStop;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (rxd_s) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              state_d    = StIdle;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StWaitHigh;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StWaitHigh: begin
          // A held-low line (break) must return high before a new frame can start.
          if (rxd_s) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: the stimulus pushes expected events, a monitor pops
// and compares each time the DUT pulses rx_valid or frame_err.
module tb_uart_rx_os16;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic       tick16 = 1'b0;
  logic       rxd    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int tick_per = 4;
  int tdiv     = 0;

  // Expected events: bit 8 = frame error, bits 7:0 = rx_data required at the pulse.
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] last_good = 8'h00;

  uart_rx_os16 #(.OS(16)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .tick16   (tick16),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 sysclk = ~sysclk;

  // Tick generator: one pulse every tick_per cycles, changed away from the active edge.
  initial begin
    forever begin
      @(negedge sysclk);
      if (tdiv >= tick_per - 1) begin
        tick16 = 1'b1;
        tdiv   = 0;
      end else begin
        tick16 = 1'b0;
        tdiv++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Returns at the falling edge after the n-th tick seen by the DUT.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge sysclk);
      while (!tick16) @(posedge sysclk);
    end
    @(negedge sysclk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back({1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_ticks(16);
    end
    rxd = stop;
    wait_ticks(16);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge sysclk) begin
    if (!rst && (rx_valid || frame_err)) begin
      if (rx_valid && frame_err) begin
        checks++;
        failures++;
        $display("FAIL pulse_exclusive: got rx_valid=1 frame_err=1 expected at most one");
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got rx_valid=%0b frame_err=%0b data=%0h expected none",
                 rx_valid, frame_err, rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, mon_e[8]});
        check("pulse_rx_data", {24'd0, rx_data}, {24'd0, mon_e[7:0]});
      end
    end
  end

  logic [7:0] abort_byte;

  initial begin
    abort_byte = 8'h5A;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_ticks(20);

    // Single frame
    send_byte(8'h55, 1'b1);
    wait_ticks(16);

    // Back-to-back frames
    send_byte(8'hA3, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_ticks(16);

    // Short glitch on the line is rejected
    rxd = 1'b0;
    wait_ticks(2);
    check("glitch_busy_high", {31'd0, busy}, 32'd1);
    wait_ticks(1);
    rxd = 1'b1;
    wait_ticks(8);
    check("glitch_busy_low", {31'd0, busy}, 32'd0);
    send_byte(8'h3C, 1'b1);
    wait_ticks(16);

    // Stop bit low: frame error, line held low keeps the receiver busy
    send_byte(8'hFF, 1'b0);
    wait_ticks(20);
    check("ferr_busy_held", {31'd0, busy}, 32'd1);
    check("ferr_rx_data_kept", {24'd0, rx_data}, {24'd0, last_good});
    rxd = 1'b1;
    wait_ticks(4);
    check("ferr_busy_release", {31'd0, busy}, 32'd0);
    wait_ticks(16);

    // Break: three frame times low gives a single frame error
    exp_q.push_back({1'b1, last_good});
    rxd = 1'b0;
    wait_ticks(480);
    check("break_busy_held", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    wait_ticks(32);
    check("break_busy_release", {31'd0, busy}, 32'd0);
    send_byte(8'h81, 1'b1);
    wait_ticks(16);

    // Reset in the middle of data bit 4 abandons the frame
    rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rxd = abort_byte[i];
      wait_ticks(16);
    end
    rxd = abort_byte[4];
    wait_ticks(8);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge sysclk);
    check("abort_rx_data", {24'd0, rx_data}, 32'h00);
    check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("abort_frame_err", {31'd0, frame_err}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    last_good = 8'h00;
    rxd = 1'b1;
    wait_ticks(32);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h5A, 1'b1);
    wait_ticks(16);

    // tick16 held high continuously
    tick_per = 1;
    wait_ticks(20);
    send_byte(8'hC5, 1'b1);
    wait_ticks(16);
    check("final_rx_data", {24'd0, rx_data}, 32'hC5);

    // Bounded drain of outstanding expectations
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge sysclk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
